fmadd_pn_normalizer: RTL

FMADD_PN_NORMALIZER -- requirements
Module: fmadd_pn_normalizer

---
 rtl/fmadd_pn_normalizer_pkg.sv | 29 ++
 rtl/fmadd_norm_shifter.sv | 24 ++
 rtl/fmadd_pn_normalizer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fmadd_pn_normalizer_pkg.sv
// Shared FMADD constants: datapath widths, LZD output width and the lzc clamp,
// plus the normalizer's case classification used between pipeline stages.
package fmadd_pn_normalizer_pkg;

  // Mantissa width; equals the LZD input width.
  localparam int unsigned FMADD_MAN_W = 24;
  // Biased exponent width: half-precision field plus 2 guard bits for carry/borrow.
  localparam int unsigned FMADD_EXP_W = 7;

  // LZD constants.
  localparam int unsigned LZD_IN_W  = FMADD_MAN_W;
  localparam int unsigned LZD_CNT_W = 5;

  // Largest meaningful leading-zero count for a non-zero 24-bit mantissa.
  localparam logic [LZD_CNT_W-1:0] LZC_MAX = LZD_CNT_W'(LZD_IN_W - 1);

  // How a captured sum will be normalized in the second stage.
  typedef enum logic [1:0] {
    NormShift  = 2'd0,  // full normalization, exponent reduced by lzc
    NormDenorm = 2'd1,  // shift limited by the exponent, result subnormal
    NormZero   = 2'd2   // exact zero
  } norm_case_e;

  // Counts above LZC_MAX come from an all-zero or garbage LZD output; saturate them.
  function automatic logic [LZD_CNT_W-1:0] clamp_lzc(input logic [LZD_CNT_W-1:0] lzc);
    return (lzc > LZC_MAX) ? LZC_MAX : lzc;
  endfunction

endpackage

// File: rtl/fmadd_norm_shifter.sv
// Combinational logarithmic barrel left-shifter with a 5-bit amount.
// Bits shifted past the MSB are dropped; zeros fill from the LSB.
module fmadd_norm_shifter
  import fmadd_pn_normalizer_pkg::*;
#(
  parameter int unsigned MAN_W = FMADD_MAN_W
) (
  input  logic [MAN_W-1:0]     din,
  input  logic [LZD_CNT_W-1:0] amt,
  output logic [MAN_W-1:0]     dout
);

  logic [MAN_W-1:0] stage [0:LZD_CNT_W];

  assign stage[0] = din;

  // Stage g conditionally shifts by 2**g under control of amt[g].
  for (genvar g = 0; g < LZD_CNT_W; g++) begin : g_stage
    assign stage[g+1] = amt[g] ? (stage[g] << (2 ** g)) : stage[g];
  end

  assign dout = stage[LZD_CNT_W];

endmodule

// File: rtl/fmadd_pn_normalizer.sv
// Post-add normalizer for the fused multiply-add datapath.
// S1 captures the sum and picks the shift amount and normalization case;
// S2 performs the barrel shift and the exponent adjustment.
// Valid/ready handshake on both sides, 1 beat/cycle, 2-cycle latency.
module fmadd_pn_normalizer
  import fmadd_pn_normalizer_pkg::*;
#(
  parameter int unsigned MAN_W = FMADD_MAN_W,
  parameter int unsigned EXP_W = FMADD_EXP_W
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_W-1:0]     in_man,
  input  logic [EXP_W-1:0]     in_exp,
  input  logic                 in_sign,
  input  logic [LZD_CNT_W-1:0] in_lzc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_W-1:0]     out_man,
  output logic [EXP_W-1:0]     out_exp,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_denorm
);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;
  logic in_fire, s1_fire;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  // Flush wins over any transfer: nothing enters while clearing.
  assign in_ready = s1_adv && !flush;
  assign in_fire  = in_valid && in_ready;
  assign s1_fire  = s1_valid_q && s2_adv && !flush;

  // ---------------------------------------------------------------------------
  // S1: classify and choose the shift amount
  // ---------------------------------------------------------------------------
  logic [LZD_CNT_W-1:0] lzc_clamped;
  logic [EXP_W-1:0]     lzc_ext;
  norm_case_e           s1_case_d;
  logic [LZD_CNT_W-1:0] s1_shift_d;

  assign lzc_clamped = clamp_lzc(in_lzc);
  assign lzc_ext     = EXP_W'(lzc_clamped);

  // Shift selection; every branch keeps the later exponent subtraction non-negative.
  always_comb begin
    s1_case_d  = NormShift;
    s1_shift_d = lzc_clamped;
    if (in_man == '0) begin
      s1_case_d  = NormZero;
      s1_shift_d = '0;
    end else if (in_exp > lzc_ext) begin
      s1_case_d  = NormShift;
      s1_shift_d = lzc_clamped;
    end else if (in_exp != '0) begin
      // Here 1 <= in_exp <= 23, so the low bits hold the whole value.
      s1_case_d  = NormDenorm;
      s1_shift_d = in_exp[LZD_CNT_W-1:0] - LZD_CNT_W'(1);
    end else begin
      s1_case_d  = NormDenorm;
      s1_shift_d = '0;
    end
  end

  logic [MAN_W-1:0]     s1_man_q;
  logic [EXP_W-1:0]     s1_exp_q;
  logic                 s1_sign_q;
  norm_case_e           s1_case_q;
  logic [LZD_CNT_W-1:0] s1_shift_q;

  // S1 occupancy: cleared by flush, otherwise refilled whenever it can advance.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
    end
  end

  // S1 payload: loaded only on an accepted beat, untouched by flush.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_man_q   <= '0;
      s1_exp_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_case_q  <= NormShift;
      s1_shift_q <= '0;
    end else if (in_fire) begin
      s1_man_q   <= in_man;
      s1_exp_q   <= in_exp;
      s1_sign_q  <= in_sign;
      s1_case_q  <= s1_case_d;
      s1_shift_q <= s1_shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: shift and exponent adjust
  // ---------------------------------------------------------------------------
  logic [MAN_W-1:0] shifted_man;
  logic [EXP_W-1:0] s2_exp_d;
  logic             s2_zero_d;
  logic             s2_denorm_d;

  fmadd_norm_shifter #(
    .MAN_W (MAN_W)
  ) u_shifter (
    .din  (s1_man_q),
    .amt  (s1_shift_q),
    .dout (shifted_man)
  );

  // Exponent and flags from the case chosen in S1.
  always_comb begin
    s2_exp_d    = '0;
    s2_zero_d   = 1'b0;
    s2_denorm_d = 1'b0;
    unique case (s1_case_q)
      NormShift:  s2_exp_d    = s1_exp_q - EXP_W'(s1_shift_q);
      NormDenorm: s2_denorm_d = 1'b1;
      NormZero:   s2_zero_d   = 1'b1;
      default:    s2_exp_d    = '0;
    endcase
  end

  logic [MAN_W-1:0] s2_man_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic             s2_sign_q;
  logic             s2_zero_q;
  logic             s2_denorm_q;

  // S2 occupancy: cleared by flush, otherwise follows S1 whenever the output moves.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s2_valid_q <= 1'b0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
    end
  end

  // S2 payload: holds while stalled so the outputs stay stable.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s2_man_q    <= '0;
      s2_exp_q    <= '0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_denorm_q <= 1'b0;
    end else if (s1_fire) begin
      s2_man_q    <= shifted_man;
      s2_exp_q    <= s2_exp_d;
      s2_sign_q   <= s1_sign_q;
      s2_zero_q   <= s2_zero_d;
      s2_denorm_q <= s2_denorm_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_man    = s2_man_q;
  assign out_exp    = s2_exp_q;
  assign out_sign   = s2_sign_q;
  assign out_zero   = s2_zero_q;
  assign out_denorm = s2_denorm_q;

endmodule
